// File: rtl/clock_divisor_frac_if.sv
// Ratio-reload handshake between a configuration source and clock_divisor_frac.
// The source offers a new integer/fractional half-period and holds it until taken.
interface clock_divisor_frac_if #(
    parameter int CNT_W  = 32,
    parameter int FRAC_W = 16
);
    logic [CNT_W-1:0]  cfg_div;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_div, output cfg_frac, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_div, input cfg_frac, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/clock_divisor_frac.sv
// Fractional clock divider: dual-modulus N / N+1 half-periods chosen by a phase
// accumulator carry, with a shadowed ratio that is applied only at rising edges.
module clock_divisor_frac #(
    parameter int CNT_W      = 32,
    parameter int FRAC_W     = 16,
    parameter int RESET_DIV  = 1000,
    parameter int RESET_FRAC = 0
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                en,
    clock_divisor_frac_if.slave cfg,
    output logic                clk_out,
    output logic                tick_rise,
    output logic                tick_fall,
    output logic                running
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0]  DIV_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DIV_INIT  = (RESET_DIV == 0) ? DIV_ONE : CNT_W'(RESET_DIV);
    localparam logic [FRAC_W-1:0] FRAC_INIT = FRAC_W'(RESET_FRAC);

    state_t            state;
    logic [CNT_W-1:0]  div_q;
    logic [CNT_W-1:0]  sh_div;
    logic [CNT_W-1:0]  count;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] acc;
    logic              ext;
    logic              pend;

    logic [CNT_W:0]    half_len;
    logic [FRAC_W:0]   acc_sum;
    logic              terminal;
    logic              xfer;

    // One extra bit so div_q at its maximum plus a carry does not wrap to zero.
    assign half_len      = {1'b0, div_q} + (CNT_W+1)'(ext);
    assign terminal      = ({1'b0, count} == half_len - (CNT_W+1)'(1));
    assign acc_sum       = {1'b0, acc} + {1'b0, frac_q};
    assign xfer          = cfg.cfg_valid && !pend;
    assign cfg.cfg_ready = !pend;

    // NOTE: every register here is updated with <= so each branch reads the
    // pre-edge values of its peers, whatever order the statements appear in.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            running   <= 1'b0;
            div_q     <= DIV_INIT;
            frac_q    <= FRAC_INIT;
            sh_div    <= DIV_INIT;
            sh_frac   <= FRAC_INIT;
            pend      <= 1'b0;
            count     <= '0;
            acc       <= '0;
            ext       <= 1'b0;
        end else begin
            // NOTE: pulses default low up front so each one lasts exactly one cycle.
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;

            if (xfer) begin
                sh_div  <= (cfg.cfg_div == '0) ? DIV_ONE : cfg.cfg_div;
                sh_frac <= cfg.cfg_frac;
                pend    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    count   <= '0;
                    acc     <= '0;
                    ext     <= 1'b0;
                    if (pend) begin
                        div_q  <= sh_div;
                        frac_q <= sh_frac;
                        pend   <= 1'b0;
                    end
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end

                RUN: begin
                    if (!en && !clk_out) begin
                        // Stopping in the low phase: no further edge at all.
                        state   <= IDLE;
                        running <= 1'b0;
                        count   <= '0;
                        acc     <= '0;
                        ext     <= 1'b0;
                    end else if (terminal) begin
                        clk_out   <= !clk_out;
                        count     <= '0;
                        tick_rise <= !clk_out;
                        tick_fall <= clk_out;
                        if (!clk_out && pend) begin
                            div_q  <= sh_div;
                            frac_q <= sh_frac;
                            pend   <= 1'b0;
                            acc    <= '0;
                            ext    <= 1'b0;
                        end else if (clk_out && !en) begin
                            state   <= IDLE;
                            running <= 1'b0;
                            acc     <= '0;
                            ext     <= 1'b0;
                        end else begin
                            {ext, acc} <= acc_sum;
                        end
                    end else begin
                        count <= count + DIV_ONE;
                        if (!en) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (terminal) begin
                        clk_out   <= 1'b0;
                        tick_fall <= 1'b1;
                        count     <= '0;
                        acc       <= '0;
                        ext       <= 1'b0;
                        state     <= IDLE;
                        running   <= 1'b0;
                    end else begin
                        count <= count + DIV_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clock_divisor_frac.sv
// Bench for clock_divisor_frac: edge times predicted from closed-form carry
// arithmetic and compared cycle by cycle, under directed and random ratios.
module tb_clock_divisor_frac;
    localparam int CW   = 4;
    localparam int FW   = 8;
    localparam int RDIV = 6;

    logic clk_in = 1'b0;
    logic rst;
    logic en;
    logic clk_out;
    logic tick_rise;
    logic tick_fall;
    logic running;

    int checks = 0;
    int errors = 0;
    int cur_n;
    int cur_f;

    clock_divisor_frac_if #(.CNT_W(CW), .FRAC_W(FW)) bus ();

    clock_divisor_frac #(
        .CNT_W(CW), .FRAC_W(FW), .RESET_DIV(RDIV), .RESET_FRAC(0)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg       (bus),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .running   (running)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    // Extra cycle of half-period j after a ratio load: the carry out of j*F / 2^FW.
    function automatic int ext_of(input int j, input int f);
        if (j == 0) return 0;
        return ((j * f) >> FW) - (((j - 1) * f) >> FW);
    endfunction

    task automatic idle_cfg(input int n, input int f);
        @(negedge clk_in);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = CW'(n);
        bus.cfg_frac  = FW'(f);
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        check("idle_cfg/pend", bus.cfg_ready, 0);
        @(negedge clk_in);
        check("idle_cfg/applied", bus.cfg_ready, 1);
        cur_n = n;
        cur_f = f;
    endtask

    // Start from IDLE with ratio (n1,f1); optionally offer (n2,f2) after edge tc;
    // en is sampled high at edges 0..t_stop and low afterwards.
    task automatic run_case(input string tag, input int n1, input int f1, input int n2,
                            input int f2, input int tc, input int t_stop);
        int bq[$];
        int n, f, j, t, tx, apply_e, s, nb, lvl_stop, ready_back, t_end, garbage, tt, nbt;
        bit hit;
        logic [4:0] expv;

        n = eff(n1); f = f1; j = 0; t = 0; apply_e = -1;
        tx = (tc >= 0) ? tc + 1 : -1;
        while (t <= t_stop + 40) begin
            t += n + ext_of(j, f);
            if ((bq.size() % 2 == 0) && tx >= 0 && apply_e < 0 && t > tx && t <= t_stop) begin
                apply_e = t; n = eff(n2); f = f2; j = 0;
            end else begin
                j++;
            end
            bq.push_back(t);
        end
        nb = 0;
        foreach (bq[i]) if (bq[i] <= t_stop) nb++;
        lvl_stop   = nb % 2;
        s          = (lvl_stop == 1) ? bq[nb] : t_stop + 1;
        ready_back = (apply_e >= 0) ? apply_e : s + 1;
        t_end      = s + 3;

        @(negedge clk_in);
        check({tag, "/idle"}, {clk_out, tick_rise, tick_fall, running, bus.cfg_ready}, 5'b00001);
        en = 1'b1;
        @(negedge clk_in);
        garbage = 0;
        for (int k = 0; k < t_end; k++) begin
            en = (k + 1 <= t_stop);
            bus.cfg_valid = 1'b0;
            if (k == tc) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_div   = CW'(n2);
                bus.cfg_frac  = FW'(f2);
            end else if (tc >= 0 && k > tc && garbage < 3 && !bus.cfg_ready) begin
                // Offers made while the slot is full must be ignored.
                bus.cfg_valid = 1'b1;
                bus.cfg_div   = CW'($urandom);
                bus.cfg_frac  = FW'($urandom);
                garbage++;
            end
            @(negedge clk_in);
            tt  = k + 1;
            nbt = 0;
            foreach (bq[i]) if (bq[i] <= tt) nbt++;
            hit = (nbt > 0) && (bq[nbt-1] == tt);
            if (tt < s)       expv[4:1] = {1'(nbt % 2), hit && (nbt % 2 == 1), hit && (nbt % 2 == 0), 1'b1};
            else if (tt == s) expv[4:1] = {1'b0, 1'b0, 1'(lvl_stop), 1'b0};
            else              expv[4:1] = 4'b0000;
            expv[0] = (tx < 0) ? 1'b1 : !(tt >= tx && tt < ready_back);
            check($sformatf("%s@%0d", tag, tt),
                  {clk_out, tick_rise, tick_fall, running, bus.cfg_ready}, expv);
        end
        bus.cfg_valid = 1'b0;
        en = 1'b0;
        if (tc >= 0) begin
            cur_n = n2;
            cur_f = f2;
        end
    endtask

    initial begin
        int n2, f2, ts, tc;
        rst = 1'b1;
        en  = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_frac  = '0;
        repeat (3) @(negedge clk_in);
        check("reset", {clk_out, tick_rise, tick_fall, running, bus.cfg_ready}, 5'b00001);
        rst   = 1'b0;
        cur_n = RDIV;
        cur_f = 0;

        run_case("reset_div", cur_n, cur_f, 0, 0, -1, 20);
        idle_cfg(3, 0);
        run_case("n3", 3, 0, 0, 0, -1, 16);
        run_case("drop_high", 3, 0, 0, 0, -1, 4);
        run_case("drop_low", 3, 0, 0, 0, -1, 7);
        idle_cfg(2, 1 << (FW - 1));
        run_case("n2_half", 2, 1 << (FW - 1), 0, 0, -1, 60);
        idle_cfg(4, 0);
        run_case("reconfig", 4, 0, 2, 0, 5, 30);
        idle_cfg(0, 0);
        run_case("div0", 0, 0, 0, 0, -1, 12);
        idle_cfg(15, 255);
        run_case("wrap", 15, 255, 0, 0, -1, 70);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1, 0) == 1) idle_cfg(int'($urandom_range(15, 0)), int'($urandom_range(255, 0)));
            n2 = int'($urandom_range(15, 0));
            f2 = int'($urandom_range(255, 0));
            ts = int'($urandom_range(60, 4));
            if ($urandom_range(1, 0) == 1) tc = int'($urandom_range(ts - 1, 0));
            else                           tc = -1;
            run_case($sformatf("rnd%0d", i), cur_n, cur_f, n2, f2, tc, ts);
        end

        // Reset during the high phase with a ratio pending.
        idle_cfg(4, 0);
        @(negedge clk_in);
        en = 1'b1;
        repeat (6) @(negedge clk_in);
        check("rst_mid/high", clk_out, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = CW'(2);
        bus.cfg_frac  = FW'(0);
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        check("rst_mid/pend", bus.cfg_ready, 0);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk_in);
        check("rst_mid/outs", {clk_out, tick_rise, tick_fall, running, bus.cfg_ready}, 5'b00001);
        rst   = 1'b0;
        cur_n = RDIV;
        cur_f = 0;
        run_case("post_rst", cur_n, cur_f, 0, 0, -1, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
